number_assembler: RTL
=====================

# number_assembler

Converts the classified byte stream from the character-classification stage into unsigned binary integers. Sits directly downstream of it: each accepted byte arrives with its digit/separator flags, consecutive ASCII digits are accumulated in decimal, and a completed value is emitted as a one-cycle strobe when a separator or flush ends the token. Tokens containing any other character are dropped and flagged.

## Interface
- WIDTH, 16: result width in bits; maximum representable value is 2^WIDTH-1.
- MAX_DIGITS, 5: maximum significant digits per token. Leading zeros are not counted.

- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  data_in, is_number and is_white carry a new byte this cycle.
- data_in  input  8  ASCII byte from the classification stage.
- is_number  input  1  byte is '0'..'9'.
- is_white  input  1  byte is a separator (' ' or '-').
- flush  input  1  end of stream: terminates the current token.
- num_out  output  WIDTH  last emitted value; held until the next emission.
- num_valid  output  1  one-cycle strobe: num_out and num_overflow are new.
- num_overflow  output  1  emitted value saturated; qualified by num_valid.
- err_token  output  1  one-cycle strobe: current token discarded.
- busy  output  1  a token is in progress (state ACCUM or DISCARD).

## Operation
- States:
  - IDLE: between tokens.
  - ACCUM: digits being collected.
  - DISCARD: invalid token, skipping to the next separator.
- Internal registers:
  - acc: WIDTH bits.
  - cnt: significant-digit counter.
  - ovf: sticky overflow flag.
- Digit value d = data_in[3:0]. Valid only when is_number=1.
- A byte is "other" when valid_in=1, is_number=0 and is_white=0.
- The update acc*10+d is computed at WIDTH+4 bits.
  - Overflow condition: the result exceeds 2^WIDTH-1, or cnt would exceed MAX_DIGITS.
  - On overflow: acc saturates to all-ones and ovf is set. It stays saturated for the rest of the token.
- cnt increments only when the new acc is nonzero. Leading zeros are therefore free.
- IDLE transitions:
  - digit: acc=d, cnt=(d!=0), ovf=0, go to ACCUM.
  - separator: stay in IDLE.
  - other: pulse err_token, go to DISCARD.
  - flush: stay in IDLE, no output.
- ACCUM transitions:
  - digit: accumulate as above.
  - separator or flush: num_out=acc, num_overflow=ovf, pulse num_valid, go to IDLE.
  - other: pulse err_token, go to DISCARD. No emission.
- DISCARD transitions:
  - separator or flush: go to IDLE.
  - digit or other: stay in DISCARD.
  - err_token does not repeat while in DISCARD.
- flush together with valid_in: flush wins and the byte is ignored.
- Cycles with valid_in=0 and flush=0 leave all state unchanged.
- There is no backpressure. The consumer must sample every num_valid strobe.

## Timing
- All outputs are registered. Reset values:
  - num_out = 0
  - num_valid = 0
  - num_overflow = 0
  - err_token = 0
  - busy = 0
  - state = IDLE, acc = 0, cnt = 0, ovf = 0.
- Latency: num_valid and err_token rise on the clock edge that samples the terminating or offending byte. They are visible one cycle after valid_in, high for exactly one cycle.
- Back-to-back valid_in every cycle is supported with no bubbles. The sequence digit, separator, digit emits and restarts without lost bytes.
- rst asserted mid-token aborts the token immediately. No emission or strobe occurs after deassertion.
- busy reflects the registered state. It falls in the same cycle num_valid rises.

## Test plan
- Token "12 ", bytes one per cycle → num_valid pulses once with num_out=12, num_overflow=0, one cycle after the ' ' byte.
- Tokens "65535 " then "65536 " → first emits 65535 with num_overflow=0; second emits 65535 with num_overflow=1.
- Token "000042-" (leading zeros, '-' as separator) → emits 42, num_overflow=0. Separately, "123456 " → emits 65535 with num_overflow=1.
- Sequence "1a2 3" then flush → err_token pulses once on 'a' and no emission for "1a2". After flush, emits 3. A flush asserted together with a digit byte drops that byte.
- Sequence "7-8 " with valid_in high every cycle → emits 7, then 8 two cycles later. Gaps with valid_in=0 inserted mid-token do not change the results.
- Send "98", assert rst for one cycle, then send " 5 " → no emission for 98, then emits 5. All outputs read reset values during rst.

Source files
------------

// File: rtl/number_assembler.sv
// Accumulates ASCII decimal digit tokens into saturating unsigned integers.
// Emits a one-cycle strobe when a separator or flush ends a token; tokens with other bytes are dropped.
module number_assembler #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [7:0]       data_in,
    input  logic             is_number,
    input  logic             is_white,
    input  logic             flush,
    output logic [WIDTH-1:0] num_out,
    output logic             num_valid,
    output logic             num_overflow,
    output logic             err_token,
    output logic             busy
);

    localparam int unsigned     CW   = $clog2(MAX_DIGITS + 2);
    localparam logic [WIDTH+3:0] TEN  = (WIDTH + 4)'(10);
    localparam logic [WIDTH+3:0] MAXV = {4'b0000, {WIDTH{1'b1}}};
    localparam logic [CW-1:0]    CMAX = CW'(MAX_DIGITS);

    typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q, acc_d, num_q;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             ovf_q, ovf_d;
    logic             num_valid_q, num_ovf_q, err_q, busy_q;
    logic [3:0]       d;
    logic [WIDTH+3:0] mac;
    logic             take, is_dig, is_sep, is_oth;
    logic             unused_hi;

    assign d         = data_in[3:0];
    assign unused_hi = ^data_in[7:4];

    always_comb begin
        // flush takes priority over any byte presented in the same cycle
        take    = valid_in & ~flush;
        is_dig  = take & is_number;
        is_sep  = take & ~is_number & is_white;
        is_oth  = take & ~is_number & ~is_white;
        mac     = {4'b0000, acc_q} * TEN + {{WIDTH{1'b0}}, d};
        cnt_inc = cnt_q + {{(CW-1){1'b0}}, (mac != '0)};
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (ovf_q || (mac > MAXV) || (cnt_inc > CMAX)) begin
            acc_d = '1;
            ovf_d = 1'b1;
        end else begin
            acc_d = mac[WIDTH-1:0];
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            num_q       <= '0;
            num_valid_q <= 1'b0;
            num_ovf_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            num_valid_q <= 1'b0;
            err_q       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (is_dig) begin
                        acc_q   <= {{(WIDTH-4){1'b0}}, d};
                        cnt_q   <= {{(CW-1){1'b0}}, (d != 4'd0)};
                        ovf_q   <= 1'b0;
                        state_q <= ACCUM;
                        busy_q  <= 1'b1;
                    end else if (is_oth) begin
                        err_q   <= 1'b1;
                        state_q <= DISCARD;
                        busy_q  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (flush || is_sep) begin
                        num_q       <= acc_q;
                        num_ovf_q   <= ovf_q;
                        num_valid_q <= 1'b1;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end else if (is_dig) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                    end else if (is_oth) begin
                        err_q   <= 1'b1;
                        state_q <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (flush || is_sep) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign num_out      = num_q;
    assign num_valid    = num_valid_q;
    assign num_overflow = num_ovf_q;
    assign err_token    = err_q;
    assign busy         = busy_q;

endmodule
